parking_lot_ctrl: RTL and testbench
===================================

Name: parking_lot_ctrl

Overview:
Multi-lane parking-lot controller. Each of LANES gates has an A/B sensor pair. A per-lane direction FSM tracks the complete A/B crossing sequence and emits one-cycle enter/exit pulses. A shared saturating occupancy counter sums all lanes every cycle and drives full/empty/overflow/underflow status for the gate-lamp and display logic.

Parameters:
LANES, 2, number of independent gate lanes (1..8).
CAPACITY, 100, maximum occupancy; count never exceeds this.
CNT_W, 7, count width; 2**CNT_W must be greater than CAPACITY.
DEBOUNCE_CYC, 4, stable-sample cycles required per sensor (used only with PLC_DEBOUNCE_EN).

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-high reset.
sens_a  input  LANES  sensor A per lane, outside sensor, 1 = blocked; asynchronous.
sens_b  input  LANES  sensor B per lane, inside sensor, 1 = blocked; asynchronous.
err_clr  input  1  synchronous clear of all lane_err bits.
enter  output  LANES  one-cycle pulse per completed entry.
exit  output  LANES  one-cycle pulse per completed exit.
count  output  CNT_W  current occupancy.
full  output  1  count == CAPACITY.
empty  output  1  count == 0.
ovf  output  1  one-cycle pulse: entries were clipped at CAPACITY.
udf  output  1  one-cycle pulse: exits were clipped at 0.
lane_err  output  LANES  sticky per-lane illegal-sequence flag.

Behaviour:
- Reset (async, active-high) forces all sync flops to 0, all FSMs to IDLE, enter/exit/ovf/udf to 0, count to 0, lane_err to 0, empty to 1 and full to 0.
- Each sens_a/sens_b bit passes through a 2-FF synchroniser. The FSM acts on the synchronised pair {a,b}.
- Lane FSM states: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A. All transitions are registered.
- IDLE: 10 -> IN_A; 01 -> OUT_B; 00 stays; 11 -> IDLE and sets lane_err.
- Entry path, IN_A: 11 -> IN_AB; 00 -> IDLE (abort, no pulse); 01 -> IDLE and sets lane_err.
- IN_AB: 01 -> IN_B; 10 -> IN_A (backing out).
- IN_B: 00 -> IDLE and asserts enter[i] on that edge; 11 -> IN_AB; 10 -> IDLE and sets lane_err.
- Exit path mirrors the entry path: OUT_B -> OUT_AB -> OUT_A -> IDLE, asserting exit[i]. Aborts and errors are symmetric to the entry path.
- enter/exit are high for exactly 1 cycle. A lane never asserts both at once.
- Latency without debounce: the FSM sees a sensor change on the 2nd clk edge after it arrives. The pulse is high after the 3rd edge; count updates on the 4th edge.
- Counter: each cycle n_in = popcount(enter) and n_out = popcount(exit); next = count + n_in - n_out, computed at CNT_W+4 bits signed.
- next > CAPACITY: count = CAPACITY and ovf pulses.
- next < 0: count = 0 and udf pulses.
- Otherwise count = next.
- Simultaneous entries and exits in the same cycle net out first; clipping applies only to the net result.
- full and empty are registered together with count, so they change on the same edge.
- lane_err is sticky until err_clr. If err_clr and a new error occur in the same cycle, the error wins.
- Entry is counted even when full (clipped to CAPACITY, ovf). Gate lockout is external.
- Reset mid-sequence drops the partial crossing with no pulse. After reset release, a lane whose sensors sit at 11 or 01 follows the IDLE rules above.

Optional Feature:
PLC_DEBOUNCE_EN
- Defined: each synchronised sensor bit feeds a per-bit counter. The filtered value changes only after DEBOUNCE_CYC consecutive identical samples that differ from the current filtered value. Glitches shorter than DEBOUNCE_CYC cycles are ignored. Latency grows by DEBOUNCE_CYC cycles.
- Undefined: the FSM uses the synchroniser output directly, and DEBOUNCE_CYC is ignored.

Test Plan:
1. Lane 0 sequence 00,10,11,01,00 (10 cycles per step) -> enter[0] pulses once; count goes 0->1; empty falls on the same edge.
2. Lane 1 sequence 01,11,10,00 with count=1 -> exit[1] pulses once; count 1->0; empty=1. A further exit gives count 0 and udf pulses.
3. CAPACITY=3: four entries, then lanes 0 and 1 complete entry and exit on the same edge -> count stays at 3; ovf fires only on the 4th entry; net-zero cycle gives no ovf.
4. Lane 0 sequence 10,11,10,00 (back-out) -> no enter, count unchanged. IDLE->11 jump -> lane_err[0]=1, held until err_clr pulse clears it.
5. Reset asserted while lane 0 is in IN_B, released with sensors at 00 -> no enter pulse, count=0, all outputs at reset values.
6. With PLC_DEBOUNCE_EN and DEBOUNCE_CYC=4: 2-cycle glitch on sens_a[0] -> FSM stays IDLE. A full entry with 8-cycle steps -> enter[0] pulses, delayed a further 4 cycles versus the non-debounced build.

Source files
------------

// File: rtl/parking_lot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_ctrl
// Brief    : Multi-lane A/B gate crossing FSMs feeding a shared saturating
//            occupancy counter. Build macro: PLC_DEBOUNCE_EN (sensor filter).
// Revision : 1.0 - initial release
// ============================================================================
module parking_lot_ctrl #(
  parameter int LANES        = 2,
  parameter int CAPACITY     = 100,
  parameter int CNT_W        = 7,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] sens_a,
  input  logic [LANES-1:0] sens_b,
  input  logic             err_clr,
  output logic [LANES-1:0] enter,
  output logic [LANES-1:0] exit,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf,
  output logic [LANES-1:0] lane_err
);

  localparam int c_sum_w = CNT_W + 4;
  localparam logic signed [c_sum_w-1:0] c_cap_s = c_sum_w'(CAPACITY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IN_A   = 3'd1,
    S_IN_AB  = 3'd2,
    S_IN_B   = 3'd3,
    S_OUT_B  = 3'd4,
    S_OUT_AB = 3'd5,
    S_OUT_A  = 3'd6
  } lane_state_t;

  if (LANES < 1 || LANES > 8 || CAPACITY >= (1 << CNT_W) || DEBOUNCE_CYC < 1) begin : g_bad_params
    $error("parking_lot_ctrl: illegal parameter combination");
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  w_ab;
    lane_state_t r_state;
    lane_state_t w_state_nxt;
    logic        w_enter_nxt;
    logic        w_exit_nxt;
    logic        w_err_nxt;
    logic        r_enter;
    logic        r_exit;
    logic        r_err;

    // Bit 1 carries sensor A (outside), bit 0 sensor B (inside).
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync1 <= 2'b00;
        r_sync2 <= 2'b00;
      end else begin
        r_sync1 <= {sens_a[gi], sens_b[gi]};
        r_sync2 <= r_sync1;
      end
    end

`ifdef PLC_DEBOUNCE_EN
    localparam int c_db_w = $clog2(DEBOUNCE_CYC + 1);

    for (genvar gb = 0; gb < 2; gb++) begin : g_db
      logic [c_db_w-1:0] r_cnt;
      logic              r_filt;

      // Counts consecutive samples that disagree with the filtered value.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (r_sync2[gb] == r_filt) begin
          r_cnt  <= '0;
        end else if (r_cnt == c_db_w'(DEBOUNCE_CYC - 1)) begin
          r_filt <= r_sync2[gb];
          r_cnt  <= '0;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end

      assign w_ab[gb] = r_filt;
    end
`else
    assign w_ab = r_sync2;
`endif

    always_comb begin
      w_state_nxt = r_state;
      w_enter_nxt = 1'b0;
      w_exit_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
        S_IDLE: begin
          case (w_ab)
            2'b10:   w_state_nxt = S_IN_A;
            2'b01:   w_state_nxt = S_OUT_B;
            2'b11:   w_err_nxt   = 1'b1;
            default: ;
          endcase
        end
        S_IN_A: begin
          case (w_ab)
            2'b11:   w_state_nxt = S_IN_AB;
            2'b00:   w_state_nxt = S_IDLE;
            2'b01: begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end
            default: ;
          endcase
        end
        S_IN_AB: begin
          case (w_ab)
            2'b01:   w_state_nxt = S_IN_B;
            2'b10:   w_state_nxt = S_IN_A;
            default: ;
          endcase
        end
        S_IN_B: begin
          case (w_ab)
            2'b00: begin
              w_state_nxt = S_IDLE;
              w_enter_nxt = 1'b1;
            end
            2'b11:   w_state_nxt = S_IN_AB;
            2'b10: begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end
            default: ;
          endcase
        end
        S_OUT_B: begin
          case (w_ab)
            2'b11:   w_state_nxt = S_OUT_AB;
            2'b00:   w_state_nxt = S_IDLE;
            2'b10: begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end
            default: ;
          endcase
        end
        S_OUT_AB: begin
          case (w_ab)
            2'b10:   w_state_nxt = S_OUT_A;
            2'b01:   w_state_nxt = S_OUT_B;
            default: ;
          endcase
        end
        S_OUT_A: begin
          case (w_ab)
            2'b00: begin
              w_state_nxt = S_IDLE;
              w_exit_nxt  = 1'b1;
            end
            2'b11:   w_state_nxt = S_OUT_AB;
            2'b01: begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end
            default: ;
          endcase
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= S_IDLE;
        r_enter <= 1'b0;
        r_exit  <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_enter <= w_enter_nxt;
        r_exit  <= w_exit_nxt;
        if (w_err_nxt)
          r_err <= 1'b1;
        else if (err_clr)
          r_err <= 1'b0;
      end
    end

    assign enter[gi]    = r_enter;
    assign exit[gi]     = r_exit;
    assign lane_err[gi] = r_err;
  end

  logic [3:0]                w_n_in;
  logic [3:0]                w_n_out;
  logic signed [c_sum_w-1:0] w_next;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      w_ovf_nxt;
  logic                      w_udf_nxt;

  always_comb begin
    w_n_in  = 4'd0;
    w_n_out = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      w_n_in  = w_n_in  + 4'(enter[i]);
      w_n_out = w_n_out + 4'(exit[i]);
    end
  end

  // Entries and exits of one cycle net out before clipping.
  assign w_next = $signed({4'b0000, count})
                + $signed({{CNT_W{1'b0}}, w_n_in})
                - $signed({{CNT_W{1'b0}}, w_n_out});

  always_comb begin
    w_cnt_nxt = w_next[CNT_W-1:0];
    w_ovf_nxt = 1'b0;
    w_udf_nxt = 1'b0;
    if (w_next[c_sum_w-1]) begin
      w_cnt_nxt = '0;
      w_udf_nxt = 1'b1;
    end else if (w_next > c_cap_s) begin
      w_cnt_nxt = CNT_W'(CAPACITY);
      w_ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= w_cnt_nxt;
      full  <= (w_cnt_nxt == CNT_W'(CAPACITY));
      empty <= (w_cnt_nxt == '0);
      ovf   <= w_ovf_nxt;
      udf   <= w_udf_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_ctrl.sv
`default_nettype none
// Testbench for parking_lot_ctrl: directed scenarios plus randomized lane
// traffic checked against a cycle-scheduled occupancy model.
module tb_parking_lot_ctrl;

  localparam int LANES    = 2;
  localparam int CAPACITY = 3;
  localparam int CNT_W    = 4;
  localparam int NCYC     = 2000;
  localparam int MAXC     = NCYC + 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             err_clr;
  logic [LANES-1:0] sens_a;
  logic [LANES-1:0] sens_b;
  logic [LANES-1:0] enter;
  logic [LANES-1:0] exit;
  logic [LANES-1:0] lane_err;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             udf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] p_en0, p_en1, p_ex0, p_ex1, p_ovf, p_udf, p_empty;

  logic [LANES-1:0] m_en   [0:MAXC-1];
  logic [LANES-1:0] m_ex   [0:MAXC-1];
  logic [LANES-1:0] m_eset [0:MAXC-1];
  logic             m_clr  [0:MAXC-1];
  int               m_in   [0:MAXC-1];
  int               m_out  [0:MAXC-1];

  parking_lot_ctrl #(
    .LANES(LANES), .CAPACITY(CAPACITY), .CNT_W(CNT_W), .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
    .err_clr(err_clr), .enter(enter), .exit(exit), .count(count),
    .full(full), .empty(empty), .ovf(ovf), .udf(udf), .lane_err(lane_err)
  );

  always #5 clk = ~clk;

  task automatic set_lane(input int l, input logic [1:0] v);
    sens_a[l] = v[1];
    sens_b[l] = v[0];
  endtask

  task automatic apply(input int l, input logic [1:0] v, input int n);
    @(posedge clk); #1;
    set_lane(l, v);
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic apply2(input logic [1:0] v0, input logic [1:0] v1, input int n);
    @(posedge clk); #1;
    set_lane(0, v0);
    set_lane(1, v1);
    repeat (n - 1) @(posedge clk);
  endtask

  // Step j of the sequence sits in seq[2*j +: 2].
  task automatic run_seq(input int l, input logic [7:0] seq, input int n, input int hold);
    for (int j = 0; j < n; j++) apply(l, seq[2*j +: 2], hold);
  endtask

  // Drive all sensors clear, then record outputs after each of the next 8 edges.
  task automatic finish_capture();
    @(posedge clk); #1;
    sens_a = '0;
    sens_b = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      p_en0[i] = enter[0];   p_en1[i] = enter[1];
      p_ex0[i] = exit[0];    p_ex1[i] = exit[1];
      p_ovf[i] = ovf;        p_udf[i] = udf;
      p_empty[i] = empty;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; err_clr = 1'b0; sens_a = '0; sens_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if ({count, full, empty} !== {CNT_W'(0), 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_in_reset count/full/empty got %0d/%b/%b exp 0/0/1", count, full, empty);
    end
    n_tests++;
    reset = 1'b0;
    @(negedge clk);
    if ({enter, exit} !== '0) begin
      n_fail++; $display("FAIL reset_pulses got %b exp 0", {enter, exit});
    end
    n_tests++;
    if ({count, full, empty} !== {CNT_W'(0), 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_count got %0d/%b/%b exp 0/0/1", count, full, empty);
    end
    n_tests++;
    if ({ovf, udf, lane_err} !== '0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0", {ovf, udf, lane_err});
    end
    n_tests++;
  endtask

  task automatic test_entry();
    apply(0, 2'b00, 10);
    run_seq(0, 8'b00_01_11_10, 3, 10);
    finish_capture();
    if (p_en0 !== 8'b0000_0100) begin
      n_fail++; $display("FAIL entry_pulse got %b exp 00000100", p_en0);
    end
    n_tests++;
    if ({p_ex0, p_en1, p_ex1} !== '0) begin
      n_fail++; $display("FAIL entry_other_pulses got %b exp 0", {p_ex0, p_en1, p_ex1});
    end
    n_tests++;
    if (p_empty !== 8'b0000_0111) begin
      n_fail++; $display("FAIL entry_empty_timing got %b exp 00000111", p_empty);
    end
    n_tests++;
    if (count !== CNT_W'(1)) begin
      n_fail++; $display("FAIL entry_count got %0d exp 1", count);
    end
    n_tests++;
  endtask

  task automatic test_exit_udf();
    run_seq(1, 8'b00_10_11_01, 3, 10);
    finish_capture();
    if (p_ex1 !== 8'b0000_0100) begin
      n_fail++; $display("FAIL exit_pulse got %b exp 00000100", p_ex1);
    end
    n_tests++;
    if (count !== CNT_W'(0) || p_empty !== 8'b1111_1000) begin
      n_fail++; $display("FAIL exit_count count %0d empty %b exp 0 11111000", count, p_empty);
    end
    n_tests++;
    if (p_udf !== 8'h00) begin
      n_fail++; $display("FAIL exit_no_udf got %b exp 0", p_udf);
    end
    n_tests++;
    run_seq(1, 8'b00_10_11_01, 3, 4);
    finish_capture();
    if (p_udf !== 8'b0000_1000) begin
      n_fail++; $display("FAIL udf_pulse got %b exp 00001000", p_udf);
    end
    n_tests++;
    if ({count, empty} !== {CNT_W'(0), 1'b1}) begin
      n_fail++; $display("FAIL udf_count got %0d/%b exp 0/1", count, empty);
    end
    n_tests++;
  endtask

  task automatic test_capacity();
    for (int e = 0; e < 4; e++) begin
      run_seq(0, 8'b00_01_11_10, 3, 3);
      finish_capture();
      if (p_ovf !== ((e == 3) ? 8'b0000_1000 : 8'h00)) begin
        n_fail++; $display("FAIL cap_ovf_entry%0d got %b", e, p_ovf);
      end
      n_tests++;
      if ({count, full} !== {CNT_W'((e < 3) ? e + 1 : 3), (e >= 2)}) begin
        n_fail++; $display("FAIL cap_count_entry%0d got %0d/%b", e, count, full);
      end
      n_tests++;
    end
    apply2(2'b10, 2'b01, 4);
    apply2(2'b11, 2'b11, 4);
    apply2(2'b01, 2'b10, 4);
    finish_capture();
    if ({p_en0, p_ex1} !== {8'b0000_0100, 8'b0000_0100}) begin
      n_fail++; $display("FAIL cap_simul_pulses got en0 %b ex1 %b exp 00000100 each", p_en0, p_ex1);
    end
    n_tests++;
    if ({p_ovf, p_udf} !== 16'h0000) begin
      n_fail++; $display("FAIL cap_net_zero_flags got ovf %b udf %b exp 0", p_ovf, p_udf);
    end
    n_tests++;
    if ({count, full} !== {CNT_W'(3), 1'b1}) begin
      n_fail++; $display("FAIL cap_net_zero_count got %0d/%b exp 3/1", count, full);
    end
    n_tests++;
  endtask

  task automatic test_backout_err();
    run_seq(0, 8'b00_10_11_10, 3, 4);
    finish_capture();
    if (p_en0 !== 8'h00 || count !== CNT_W'(3)) begin
      n_fail++; $display("FAIL backout got enter %b count %0d exp 0 3", p_en0, count);
    end
    n_tests++;
    apply(0, 2'b11, 6);
    @(negedge clk);
    if (lane_err !== 2'b01) begin
      n_fail++; $display("FAIL err_set got %b exp 01", lane_err);
    end
    n_tests++;
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    if (lane_err !== 2'b01) begin
      n_fail++; $display("FAIL err_wins_over_clr got %b exp 01", lane_err);
    end
    n_tests++;
    apply(0, 2'b00, 6);
    @(negedge clk);
    if (lane_err !== 2'b01) begin
      n_fail++; $display("FAIL err_sticky got %b exp 01", lane_err);
    end
    n_tests++;
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    if (lane_err !== 2'b00) begin
      n_fail++; $display("FAIL err_clr got %b exp 00", lane_err);
    end
    n_tests++;
  endtask

  task automatic test_reset_mid();
    run_seq(0, 8'b00_01_11_10, 3, 5);
    @(negedge clk);
    reset = 1'b1;
    sens_a = '0;
    sens_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    finish_capture();
    if ({p_en0, p_ex0, p_ovf, p_udf} !== '0) begin
      n_fail++; $display("FAIL rstmid_pulses got en %b ex %b ovf %b udf %b exp 0", p_en0, p_ex0, p_ovf, p_udf);
    end
    n_tests++;
    if ({count, full, p_empty, lane_err} !== {CNT_W'(0), 1'b0, 8'hFF, 2'b00}) begin
      n_fail++; $display("FAIL rstmid_state got count %0d full %b empty %b err %b exp 0 0 ff 00", count, full, p_empty, lane_err);
    end
    n_tests++;
  endtask

  function automatic int scen_len(input int s);
    case (s)
      2, 7:    return 2;
      5:       return 6;
      6:       return 1;
      default: return 4;
    endcase
  endfunction

  // Scenarios: 0 entry, 1 exit, 2 entry abort, 3 entry back-out,
  // 4 exit back-out, 5 entry with wobble, 6 idle gap, 7 illegal 11 from idle.
  function automatic logic [1:0] scen_val(input int s, input int j);
    logic [11:0] t;
    case (s)
      0:       t = {2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
      1:       t = {2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01};
      2:       t = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
      3:       t = {2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10};
      4:       t = {2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b01};
      5:       t = {2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b10};
      7:       t = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
      default: t = 12'h000;
    endcase
    return t[2*j +: 2];
  endfunction

  task automatic test_random();
    int         scen [LANES];
    int         step [LANES];
    int         hold [LANES];
    int         e_cnt;
    int         nxt;
    int         h;
    logic       e_ovf;
    logic       e_udf;
    logic [1:0] e_err;
    logic [1:0] v;

    for (int c = 0; c < MAXC; c++) begin
      m_en[c] = '0; m_ex[c] = '0; m_eset[c] = '0; m_clr[c] = 1'b0;
      m_in[c] = 0;  m_out[c] = 0;
    end
    for (int l = 0; l < LANES; l++) begin
      scen[l] = 6; step[l] = 0; hold[l] = 0;
    end
    e_cnt = 0; e_ovf = 1'b0; e_udf = 1'b0; e_err = '0;

    @(negedge clk);
    reset = 1'b1; err_clr = 1'b0; sens_a = '0; sens_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 1; k <= NCYC; k++) begin
      @(posedge clk);
      for (int l = 0; l < LANES; l++) begin
        if (m_eset[k][l]) e_err[l] = 1'b1;
        else if (m_clr[k]) e_err[l] = 1'b0;
      end
      nxt   = e_cnt + m_in[k] - m_out[k];
      e_ovf = (nxt > CAPACITY);
      e_udf = (nxt < 0);
      e_cnt = e_ovf ? CAPACITY : (e_udf ? 0 : nxt);
      #1;
      // A value driven now reaches the lane logic on the 3rd edge; the
      // counter reflects the resulting pulse one edge later.
      for (int l = 0; l < LANES; l++) begin
        if (hold[l] == 0) begin
          step[l]++;
          if (step[l] >= scen_len(scen[l])) begin
            scen[l] = $urandom_range(0, 7);
            step[l] = 0;
          end
          v = scen_val(scen[l], step[l]);
          h = $urandom_range(1, 4);
          hold[l] = h;
          set_lane(l, v);
          if (step[l] == scen_len(scen[l]) - 1) begin
            if (scen[l] == 0 || scen[l] == 5) begin
              m_en[k+3][l] = 1'b1; m_in[k+4]++;
            end else if (scen[l] == 1) begin
              m_ex[k+3][l] = 1'b1; m_out[k+4]++;
            end
          end
          if (scen[l] == 7 && step[l] == 0)
            for (int d = 3; d <= h + 2; d++) m_eset[k+d][l] = 1'b1;
        end
        if (hold[l] > 0) hold[l]--;
      end
      err_clr = ($urandom_range(0, 15) == 0);
      if (err_clr) m_clr[k+1] = 1'b1;

      @(negedge clk);
      if ({enter, exit} !== {m_en[k], m_ex[k]}) begin
        n_fail++; $display("FAIL rnd_pulses cyc %0d got %b exp %b", k, {enter, exit}, {m_en[k], m_ex[k]});
      end
      n_tests++;
      if ({count, full, empty} !== {CNT_W'(e_cnt), (e_cnt == CAPACITY), (e_cnt == 0)}) begin
        n_fail++; $display("FAIL rnd_count cyc %0d got %0d/%b/%b exp %0d", k, count, full, empty, e_cnt);
      end
      n_tests++;
      if ({ovf, udf} !== {e_ovf, e_udf}) begin
        n_fail++; $display("FAIL rnd_clip cyc %0d got ovf/udf %b%b exp %b%b", k, ovf, udf, e_ovf, e_udf);
      end
      n_tests++;
      if (lane_err !== e_err) begin
        n_fail++; $display("FAIL rnd_lane_err cyc %0d got %b exp %b", k, lane_err, e_err);
      end
      n_tests++;
    end
    err_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit_udf();
    test_capacity();
    test_backout_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
